// File: rtl/pulse_stretch_if.sv
// Tick-in / level-out bundle for the pulse stretcher.
// The master drives tick/en and the slave (the stretcher) returns the level and status pulses.
interface pulse_stretch_if;
  logic tick;
  logic en;
  logic level;
  logic busy;
  logic done_tick;
  logic miss_tick;

  modport master (
    output tick,
    output en,
    input  level,
    input  busy,
    input  done_tick,
    input  miss_tick
  );

  modport slave (
    input  tick,
    input  en,
    output level,
    output busy,
    output done_tick,
    output miss_tick
  );
endinterface

// File: rtl/pulse_stretch_fsm.sv
// Stretches single-cycle ticks into a level of HIGH_CYCLES clocks plus an optional low hold-off.
// Moore FSM with a down-counter; level/busy decode from state, done/miss are registered pulses.
//
//   state | meaning
//   IDLE  | waiting for tick & en
//   HIGH  | level high, counting down the high time
//   GAP   | level low, ticks rejected until the hold-off expires
module pulse_stretch_fsm #(
  parameter int W           = 8,
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int RETRIG      = 0
) (
  input logic            clk,
  input logic            reset,
  pulse_stretch_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Counter holds clocks remaining after the current one, hence the -1 loads.
  localparam logic [W-1:0] HIGH_LOAD = W'(HIGH_CYCLES - 1);
  localparam logic [W-1:0] GAP_LOAD  = W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [W-1:0] CNT_ONE   = W'(1);
  localparam logic [W-1:0] CNT_ZERO  = '0;
  localparam bit           HAS_GAP   = (GAP_CYCLES > 0);
  localparam bit           CAN_RETRIG = (RETRIG != 0);

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [W-1:0] count;
  logic [W-1:0] count_nxt;
  logic         done_nxt;
  logic         miss_nxt;
  logic         done_q;
  logic         miss_q;
  logic         cnt_zero;

  assign cnt_zero = (count == CNT_ZERO);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    miss_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.tick && bus.en) begin
          state_nxt = ST_HIGH;
          count_nxt = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        // A retrigger outranks expiry so the level never glitches low.
        if (bus.tick && CAN_RETRIG) begin
          count_nxt = HIGH_LOAD;
        end else begin
          miss_nxt = bus.tick;
          if (cnt_zero) begin
            done_nxt = 1'b1;
            if (HAS_GAP) begin
              state_nxt = ST_GAP;
              count_nxt = GAP_LOAD;
            end else begin
              state_nxt = ST_IDLE;
              count_nxt = CNT_ZERO;
            end
          end else begin
            count_nxt = count - CNT_ONE;
          end
        end
      end
      ST_GAP: begin
        miss_nxt = bus.tick;
        if (cnt_zero) begin
          state_nxt = ST_IDLE;
        end else begin
          count_nxt = count - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= CNT_ZERO;
      done_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      done_q <= done_nxt;
      miss_q <= miss_nxt;
    end
  end

  assign bus.level     = (state == ST_HIGH);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done_tick = done_q;
  assign bus.miss_tick = miss_q;

endmodule

// File: tb/tb_pulse_stretch_fsm.sv
// Drives four differently-configured stretchers with shared ticks and compares each
// against a remaining-clocks reference model.
module tb_pulse_stretch_fsm;

  localparam int N = 4;
  localparam int HC [N] = '{4, 4, 4, 1};
  localparam int GC [N] = '{2, 2, 0, 2};
  localparam int RT [N] = '{0, 1, 0, 0};

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic en;
  logic [N-1:0] lvl, bsy, dn, ms;

  int total = 0;
  int bad   = 0;

  // Model: clocks of high level still owed, and clocks of hold-off still owed.
  int hi_left  [N];
  int gap_left [N];
  bit e_done   [N];
  bit e_miss   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pulse_stretch_if bus ();
    assign bus.tick = tick;
    assign bus.en   = en;
    assign lvl[g]   = bus.level;
    assign bsy[g]   = bus.busy;
    assign dn[g]    = bus.done_tick;
    assign ms[g]    = bus.miss_tick;
    pulse_stretch_fsm #(
      .W(8), .HIGH_CYCLES(HC[g]), .GAP_CYCLES(GC[g]), .RETRIG(RT[g])
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hi_left[i] = 0; gap_left[i] = 0; e_done[i] = 0; e_miss[i] = 0;
    end
  endtask

  task automatic model_edge(input bit t, input bit e);
    for (int i = 0; i < N; i++) begin
      e_done[i] = 0;
      e_miss[i] = 0;
      if (hi_left[i] > 0) begin
        if (t && RT[i] != 0) begin
          hi_left[i] = HC[i];
        end else begin
          e_miss[i] = t;
          hi_left[i] = hi_left[i] - 1;
          if (hi_left[i] == 0) begin
            e_done[i]   = 1;
            gap_left[i] = GC[i];
          end
        end
      end else if (gap_left[i] > 0) begin
        e_miss[i]   = t;
        gap_left[i] = gap_left[i] - 1;
      end else if (t && e) begin
        hi_left[i] = HC[i];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("level[%0d]", i), lvl[i], hi_left[i] > 0);
      chk($sformatf("busy[%0d]", i), bsy[i], (hi_left[i] > 0) || (gap_left[i] > 0));
      chk($sformatf("done_tick[%0d]", i), dn[i], e_done[i]);
      chk($sformatf("miss_tick[%0d]", i), ms[i], e_miss[i]);
    end
  endtask

  task automatic step(input bit t, input bit e);
    tick = t;
    en   = e;
    @(posedge clk);
    model_edge(t, e);
    #1;
    check_all();
    tick = 1'b0;
  endtask

  task automatic idle(input int n, input bit e);
    for (int k = 0; k < n; k++) step(1'b0, e);
  endtask

  // Reset lands mid-cycle so its asynchronous effect is visible before any edge.
  task automatic pulse_reset();
    tick  = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    en    = 1'b0;
    model_reset();
    #2;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // single tick, then a new tick accepted on the first IDLE clock
    step(1, 1); idle(6, 1);
    step(1, 1); idle(9, 1);
    // ticks at 0, 2, 6
    step(1, 1); step(0, 1); step(1, 1); idle(3, 1); step(1, 1); idle(8, 1);
    // back-to-back for the no-gap instance: ticks at 0 and 5
    step(1, 1); idle(4, 1); step(1, 1); idle(8, 1);
    // reset mid-pulse, then a fresh pulse
    step(1, 1); step(0, 1); pulse_reset(); step(0, 1); step(1, 1); idle(9, 1);
    // en low in IDLE, and en dropped mid-pulse
    step(1, 0); idle(6, 0);
    step(1, 1); idle(2, 0); step(1, 0); idle(6, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 8);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
